// File: rtl/execute_stage.sv
// execute_stage: EX stage ALU, branch resolve and EX/MEM register; define EXEC_FORWARD_EN for operand forwarding
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_PC_plus_two,
  input  logic [15:0] in_Read_data_1,
  input  logic [15:0] in_Read_data_2,
  input  logic [15:0] in_immediate,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rt,
  input  logic [2:0]  in_rd,
  input  logic        in_ALU_Src,
  input  logic [1:0]  in_ALUOp,
  input  logic        in_RegDest,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_Branch,
  input  logic        in_MemtoReg,
  input  logic        in_RegWrite,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_RegWrite,
  input  logic [2:0]  wb_write_register,
  input  logic [15:0] wb_write_data,
  output logic        O_valid,
  output logic [15:0] O_ALU_result,
  output logic [15:0] O_write_data,
  output logic [2:0]  O_write_register,
  output logic        O_zero,
  output logic        O_MemRead,
  output logic        O_MemWrite,
  output logic        O_MemtoReg,
  output logic        O_RegWrite,
  output logic        O_PC_Src,
  output logic [15:0] O_branch_target
);
  typedef struct packed {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] wdata;
    logic [2:0]  wreg;
    logic        zero;
    logic        mr;
    logic        mw;
    logic        mt;
    logic        rw;
    logic        pcs;
    logic [15:0] bt;
  } ex_mem_t;
  ex_mem_t q, d;
  logic [15:0] a, rt_v, b, res, f_res;
  logic [3:0] funct;
`ifdef EXEC_FORWARD_EN
  function automatic logic [15:0] fwd(input logic [2:0] src, input logic [15:0] rd);
    return (src != 3'd0 && q.valid && q.rw && !q.mt && q.wreg == src) ? q.alu :
           (src != 3'd0 && wb_RegWrite && wb_write_register == src) ? wb_write_data : rd;
  endfunction
  assign a    = fwd(in_rs, in_Read_data_1);
  assign rt_v = fwd(in_rt, in_Read_data_2);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_RegWrite, wb_write_register, wb_write_data};
  assign a    = in_Read_data_1;
  assign rt_v = in_Read_data_2;
`endif
  assign b = in_ALU_Src ? in_immediate : rt_v;
  assign funct = in_immediate[3:0];
  always_comb begin
    f_res = funct == 4'd0 ? a + b :
            funct == 4'd1 ? a - b :
            funct == 4'd2 ? a & b :
            funct == 4'd3 ? a | b :
            funct == 4'd4 ? (($signed(a) < $signed(b)) ? 16'd1 : 16'd0) :
            funct == 4'd5 ? ~(a | b) : 16'h0000;
    res = in_ALUOp == 2'b00 ? a + b :
          in_ALUOp == 2'b01 ? a - b :
          in_ALUOp == 2'b11 ? a | b : f_res;
    d.valid = 1'b1;
    d.alu   = res;
    d.wdata = rt_v;
    d.wreg  = in_RegDest ? in_rd : in_rt;
    d.zero  = res == 16'h0000;
    d.mr    = in_MemRead;
    d.mw    = in_MemWrite;
    d.mt    = in_MemtoReg;
    d.rw    = in_RegWrite;
    d.pcs   = in_Branch & (res == 16'h0000) & in_valid;
    d.bt    = in_PC_plus_two + {in_immediate[14:0], 1'b0};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (flush || (!stall && !in_valid)) q <= '0;
    else if (!stall) q <= d;
  assign O_valid          = q.valid;
  assign O_ALU_result     = q.alu;
  assign O_write_data     = q.wdata;
  assign O_write_register = q.wreg;
  assign O_zero           = q.zero;
  assign O_MemRead        = q.mr;
  assign O_MemWrite       = q.mw;
  assign O_MemtoReg       = q.mt;
  assign O_RegWrite       = q.rw;
  assign O_PC_Src         = q.pcs;
  assign O_branch_target  = q.bt;
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset. Ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL accept the ID/EX bundle: in_valid 1, in_PC_plus_two 16, in_Read_data_1 16, in_Read_data_2 16, in_immediate 16 (sign-extended; [3:0] = funct), in_rs 3, in_rt 3, in_rd 3, in_ALU_Src 1, in_ALUOp 2, in_RegDest 1, in_MemRead 1, in_MemWrite 1, in_Branch 1, in_MemtoReg 1, in_RegWrite 1 (all inputs).
REQ-003 Control inputs SHALL be: stall  in  1  hold all outputs; flush  in  1  load a bubble.
REQ-004 Write-back feedback inputs SHALL be: wb_RegWrite  in  1; wb_write_register  in  3; wb_write_data  in  16.
REQ-005 The EX/MEM outputs SHALL all be registered: O_valid 1, O_ALU_result 16, O_write_data 16 (store data), O_write_register 3, O_zero 1, O_MemRead 1, O_MemWrite 1, O_MemtoReg 1, O_RegWrite 1, O_PC_Src 1, O_branch_target 16.

Function
REQ-006 Operand A SHALL be the forwarded rs value; operand B SHALL be in_immediate when in_ALU_Src=1, else the forwarded rt value.
REQ-007 ALU select SHALL be: ALUOp 00 add; 01 sub; 11 or; 10 uses funct: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt (signed, result 1 or 0), 0101 nor. Any other funct SHALL produce result 0x0000.
REQ-008 Arithmetic SHALL be 16-bit and wrap modulo 2^16, with no overflow flag or trap.
REQ-009 O_zero SHALL be 1 when the ALU result equals 0x0000.
REQ-010 O_write_register SHALL be in_rd when in_RegDest=1, else in_rt.
REQ-011 O_write_data SHALL be the forwarded rt value, independent of ALU_Src.
REQ-012 O_branch_target SHALL equal in_PC_plus_two + (in_immediate << 1), truncated to 16 bits.
REQ-013 O_PC_Src SHALL equal in_Branch AND zero AND in_valid, registered in the same edge as the other outputs.
REQ-014 Latency SHALL be one cycle: ID/EX inputs at edge N appear on the outputs after edge N.
REQ-015 When stall=1 and flush=0, every output register SHALL hold its value.
REQ-016 When flush=1, or when in_valid=0 with no stall, the block SHALL load a bubble: O_valid, O_MemRead, O_MemWrite, O_RegWrite, O_MemtoReg and O_PC_Src at 0; data outputs don't-care but deterministic 0.
REQ-017 Flush SHALL take priority over stall.
REQ-018 Register 0 SHALL read as zero: forwarding SHALL never match source index 0.
REQ-019 A bubble SHALL never assert O_PC_Src, O_MemWrite or O_RegWrite.

Reset
REQ-020 On rst_n=0, all outputs SHALL clear to 0 immediately, without waiting for a clock edge; O_valid=0.
REQ-021 On reset release, the first rising edge SHALL capture inputs normally.
REQ-022 Reset asserted during a stall SHALL clear the held values.

Configuration
REQ-023 The macro EXEC_FORWARD_EN SHALL control operand forwarding.
REQ-024 With EXEC_FORWARD_EN defined, each source operand (rs, rt) SHALL be selected in this priority order:
  - first, O_ALU_result when O_valid & O_RegWrite & !O_MemtoReg & O_write_register==src & src!=0;
  - then, wb_write_data when wb_RegWrite & wb_write_register==src & src!=0;
  - otherwise, in_Read_data.
REQ-025 Without EXEC_FORWARD_EN, operands SHALL be in_Read_data_1 and in_Read_data_2 unmodified, and the wb_* inputs SHALL be unused.

Verification
REQ-026 R-type add with funct 0000, rs=0x7FFF, rt=0x0001 -> O_ALU_result=0x8000, O_write_register=rd, O_valid=1 one cycle later.
REQ-027 beq with ALUOp 01, equal operands 0x1234, Branch=1, PC+2=0x0010, imm=0x0004 -> O_zero=1, O_PC_Src=1, O_branch_target=0x0018; the same case with imm=0xFFFE -> target 0x000C.
REQ-028 stall=1 for 3 cycles with changing inputs -> outputs frozen; flush=1 together with stall=1 -> bubble (O_valid=0, O_RegWrite=0).
REQ-029 With EXEC_FORWARD_EN: back-to-back add r1 then sub using r1 with stale read data 0 -> the sub uses the forwarded value; with src=r0 -> no forwarding.
REQ-030 rst_n asserted mid-stream between clock edges -> all outputs 0 immediately; after release, the next instruction passes with one-cycle latency.
